rv32_fetch_stage: RTL

RV32_FETCH_STAGE -- requirements
Module: rv32_fetch_stage

---
 rtl/rv32_types.sv | 20 ++
 rtl/rv32_fetch_fifo.sv | 51 +++++
 rtl/rv32_fetch_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv32_types.sv
// rv32_types: shared fetch/decode types and constants for the RV32 front end.
package rv32_types;

    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
    localparam int FETCH_FIFO_DEPTH = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_decode_buffer_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam fetch_decode_buffer_t EMPTY_BUFF = '{valid: 1'b0, pc: 32'd0, instr: RV_NOP_INSTR};

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rv32_fetch_fifo: small synchronous FIFO with flush, used for pending pcs and fetched instructions.
module rv32_fetch_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rv32_fetch_stage.sv
// rv32_fetch_stage: RV32 instruction fetch with redirect flush and decode buffer.
// Define RV_FETCH_PERF_EN to add the perf_bubble_cnt output and its counter.
module rv32_fetch_stage
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [31:0]          imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output fetch_decode_buffer_t fetch_decode_buff
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_bubble_cnt
`endif
);
    logic [31:0]          pc_q;
    logic [1:0]           drop_cnt;
    fetch_decode_buffer_t buf_q;
    logic [31:0]          pend_head;
    logic [1:0]           pend_count;
    logic                 pend_full;
    logic                 pend_empty;
    fetch_entry_t         q_head;
    fetch_entry_t         q_din;
    logic [1:0]           q_count;
    logic                 q_full;
    logic                 q_empty;
    logic                 kill;
    logic                 hs;
    logic                 rsp_live;
    logic                 load;
    logic                 bypass;
    logic                 q_push;
    logic                 q_pop;
    logic [2:0]           outstanding;

    // Live in-flight requests are exactly the entries of the pending-pc FIFO.
    assign kill           = rst || redirect_valid;
    assign outstanding    = {1'b0, pend_count} + {1'b0, drop_cnt};
    assign imem_req_valid = !kill && !pend_full && !q_full && (outstanding + {1'b0, q_count} < 3'd2);
    assign imem_req_addr  = pc_q;
    assign hs             = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && drop_cnt == 2'd0 && !pend_empty && !kill;
    assign load           = !buf_q.valid || !stall;
    assign bypass         = load && q_empty && rsp_live;
    assign q_push         = rsp_live && !bypass;
    assign q_pop          = load && !q_empty && !kill;
    assign q_din          = '{pc: pend_head, instr: imem_rsp_data};

    rv32_fetch_fifo #(.W(32), .DEPTH(FETCH_FIFO_DEPTH)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (rsp_live),
        .flush (kill),
        .din   (pc_q),
        .head  (pend_head),
        .count (pend_count),
        .full  (pend_full),
        .empty (pend_empty)
    );

    rv32_fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FETCH_FIFO_DEPTH)) u_iq (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (kill),
        .din   (q_din),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else if (redirect_valid) pc_q <= redirect_pc;
        else if (hs) pc_q <= pc_q + 32'd4;
    end

    // On reset or redirect every outstanding request not answered this cycle becomes a drop.
    always_ff @(posedge clk) begin
        if (kill) drop_cnt <= 2'(outstanding - 3'(imem_rsp_valid && outstanding != 3'd0));
        else if (imem_rsp_valid && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            buf_q.valid <= 1'b0;
        end else if (load) begin
            buf_q.valid <= !q_empty || rsp_live;
            buf_q.pc    <= q_empty ? pend_head : q_head.pc;
            buf_q.instr <= q_empty ? imem_rsp_data : q_head.instr;
        end
    end

    assign fetch_decode_buff = buf_q.valid ? buf_q : EMPTY_BUFF;

`ifdef RV_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) perf_bubble_cnt <= '0;
        else if (!buf_q.valid && !stall && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
`endif

endmodule
